// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (MA)
// requesters, with fetch starvation protection and a wait-state timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ma_req_i,
    input  logic                  ma_we_i,
    input  logic [ADDR_WIDTH-1:0] ma_addr_i,
    input  logic [DATA_WIDTH-1:0] ma_wdata_i,
    output logic                  ma_gnt_o,
    output logic                  ma_rvalid_o,
    output logic [DATA_WIDTH-1:0] ma_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  err_timeout_o
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WaitMax   = WW'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q;
    logic                  owner_ma_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ma_rdata_q;
    logic [SW-1:0]         starve_q;
    logic [WW-1:0]         wait_q;
    logic                  if_rvalid_q;
    logic                  ma_rvalid_q;
    logic                  err_q;

    logic if_gnt;
    logic ma_gnt;
    logic force_if;
    logic timeout;

    always_comb begin
        force_if = (starve_q == StarveMax);
        ma_gnt   = (state_q == StIdle) && ma_req_i && !(force_if && if_req_i);
        if_gnt   = (state_q == StIdle) && if_req_i && !ma_gnt;
        timeout  = !mem_ready_i && (wait_q == WaitMax);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            owner_ma_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            ma_rdata_q  <= '0;
            starve_q    <= '0;
            wait_q      <= '0;
            if_rvalid_q <= 1'b0;
            ma_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            ma_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_gnt || ma_gnt) begin
                        state_q    <= StAccess;
                        owner_ma_q <= ma_gnt;
                        wait_q     <= '0;
                        addr_q     <= ma_gnt ? ma_addr_i : if_addr_i;
                        we_q       <= ma_gnt && ma_we_i;
                        wdata_q    <= (ma_gnt && ma_we_i) ? ma_wdata_i : '0;
                        // Only MA wins over a waiting fetch count toward starvation
                        if (ma_gnt && if_req_i) begin
                            if (starve_q != StarveMax) starve_q <= starve_q + SW'(1);
                        end else begin
                            starve_q <= '0;
                        end
                    end
                end
                StAccess: begin
                    if (mem_ready_i || timeout) begin
                        state_q <= StIdle;
                        err_q   <= timeout;
                        if (owner_ma_q) begin
                            ma_rvalid_q <= 1'b1;
                            if (!we_q) ma_rdata_q <= timeout ? '0 : mem_rdata_i;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= timeout ? '0 : mem_rdata_i;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q == StAccess);
    assign if_gnt_o      = if_gnt;
    assign ma_gnt_o      = ma_gnt;
    assign if_rvalid_o   = if_rvalid_q;
    assign ma_rvalid_o   = ma_rvalid_q;
    assign if_rdata_o    = if_rdata_q;
    assign ma_rdata_o    = ma_rdata_q;
    assign err_timeout_o = err_q;
    assign mem_req_o     = busy_o;
    assign mem_we_o      = busy_o && we_q;
    assign mem_addr_o    = busy_o ? addr_q : '0;
    assign mem_wdata_o   = busy_o ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ma_req, ma_we, mem_ready;
    logic [31:0] if_addr, ma_addr, ma_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, busy, err_timeout;
    logic [31:0] if_rdata, ma_rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4),
        .MAX_WAIT    (15)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .ma_req_i     (ma_req),
        .ma_we_i      (ma_we),
        .ma_addr_i    (ma_addr),
        .ma_wdata_i   (ma_wdata),
        .ma_gnt_o     (ma_gnt),
        .ma_rvalid_o  (ma_rvalid),
        .ma_rdata_o   (ma_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ready_i  (mem_ready),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy),
        .err_timeout_o(err_timeout)
    );

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 0; ma_req = 0; ma_we = 0; mem_ready = 0;
        if_addr = 0; ma_addr = 0; ma_wdata = 0; mem_rdata = 0;
        next_cycle(); next_cycle(); settle();
        checks++;
        if ({if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, busy, err_timeout} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000000",
                {if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_we, busy, err_timeout});
        end
        checks++;
        if ({if_rdata, ma_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h want 0",
                if_rdata, ma_rdata, mem_addr, mem_wdata);
        end
        next_cycle(); reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        next_cycle(); if_req = 1; if_addr = 32'h100; settle();
        checks++;
        if ({if_gnt, ma_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt, ma_gnt});
        end
        next_cycle(); if_req = 0; mem_ready = 1; mem_rdata = 32'h00500093; settle();
        checks++;
        if ({mem_req, mem_we, busy, if_gnt} !== 4'b1010 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL fetch_mem: got req/we/busy/gnt=%b addr=%h want 1010 addr=100",
                {mem_req, mem_we, busy, if_gnt}, mem_addr);
        end
        next_cycle(); mem_ready = 0; mem_rdata = 32'h0; settle();
        checks++;
        if ({if_rvalid, ma_rvalid, busy, mem_req} !== 4'b1000 || if_rdata !== 32'h00500093) begin
            errors++; $display("FAIL fetch_rvalid: got rv/mrv/busy/req=%b rdata=%h want 1000 00500093",
                {if_rvalid, ma_rvalid, busy, mem_req}, if_rdata);
        end
        next_cycle(); settle();
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h00500093) begin
            errors++; $display("FAIL fetch_hold: got rv=%b rdata=%h want 0 00500093", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        next_cycle(); if_req = 1; if_addr = 32'h104; ma_req = 1; ma_we = 1;
        ma_addr = 32'h2000; ma_wdata = 32'hDEADBEEF; mem_ready = 1; settle();
        checks++;
        if ({if_gnt, ma_gnt} !== 2'b01) begin
            errors++; $display("FAIL sim_gnt: got if/ma=%b want 01", {if_gnt, ma_gnt});
        end
        next_cycle(); ma_req = 0; ma_we = 0; ma_wdata = 32'h0; settle();
        checks++;
        if ({mem_req, mem_we, if_gnt} !== 3'b110 || mem_addr !== 32'h2000 ||
            mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sim_store: got req/we/gnt=%b addr=%h wdata=%h want 110 2000 deadbeef",
                {mem_req, mem_we, if_gnt}, mem_addr, mem_wdata);
        end
        next_cycle(); mem_rdata = 32'hAAAA5555; settle();
        checks++;
        if ({ma_rvalid, if_rvalid, if_gnt} !== 3'b101 || ma_rdata !== 32'h0) begin
            errors++; $display("FAIL sim_back2back: got mrv/irv/ignt=%b ma_rdata=%h want 101 0",
                {ma_rvalid, if_rvalid, if_gnt}, ma_rdata);
        end
        next_cycle(); if_req = 0; settle();
        checks++;
        if ({mem_req, mem_we} !== 2'b10 || mem_wdata !== 32'h0 || mem_addr !== 32'h104) begin
            errors++; $display("FAIL sim_fetch_mem: got req/we=%b wdata=%h addr=%h want 10 0 104",
                {mem_req, mem_we}, mem_wdata, mem_addr);
        end
        next_cycle(); mem_ready = 0; settle();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hAAAA5555) begin
            errors++; $display("FAIL sim_fetch_rdata: got rv=%b rdata=%h want 1 aaaa5555", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_wait_states();
        next_cycle(); ma_req = 1; ma_we = 0; ma_addr = 32'h40; ma_wdata = 32'h55; mem_ready = 0; settle();
        checks++;
        if (ma_gnt !== 1'b1) begin
            errors++; $display("FAIL ws_gnt: got %b want 1", ma_gnt);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle(); ma_req = 0; mem_ready = (i == 3); mem_rdata = (i == 3) ? 32'h1234 : 32'h9999;
            settle();
            checks++;
            if ({mem_req, mem_we, err_timeout, ma_rvalid} !== 4'b1000 || mem_addr !== 32'h40 ||
                mem_wdata !== 32'h0) begin
                errors++; $display("FAIL ws_stable%0d: got req/we/err/rv=%b addr=%h wdata=%h want 1000 40 0",
                    i, {mem_req, mem_we, err_timeout, ma_rvalid}, mem_addr, mem_wdata);
            end
        end
        next_cycle(); mem_ready = 0; mem_rdata = 32'h0; settle();
        checks++;
        if ({ma_rvalid, err_timeout, busy} !== 3'b100 || ma_rdata !== 32'h1234) begin
            errors++; $display("FAIL ws_rvalid: got rv/err/busy=%b rdata=%h want 100 1234",
                {ma_rvalid, err_timeout, busy}, ma_rdata);
        end
    endtask

    task automatic test_timeout();
        next_cycle(); if_req = 1; if_addr = 32'h300; mem_ready = 0; mem_rdata = 32'hFFFFFFFF; settle();
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL to_gnt: got %b want 1", if_gnt);
        end
        for (int i = 1; i <= 16; i++) begin
            next_cycle(); if_req = 0; settle();
            checks++;
            if ({mem_req, err_timeout, if_rvalid} !== 3'b100 || mem_addr !== 32'h300) begin
                errors++; $display("FAIL to_wait%0d: got req/err/rv=%b addr=%h want 100 300",
                    i, {mem_req, err_timeout, if_rvalid}, mem_addr);
            end
        end
        next_cycle(); settle();
        checks++;
        if ({err_timeout, if_rvalid, ma_rvalid, mem_req, busy} !== 5'b11000 || if_rdata !== 32'h0) begin
            errors++; $display("FAIL to_abort: got err/irv/mrv/req/busy=%b rdata=%h want 11000 0",
                {err_timeout, if_rvalid, ma_rvalid, mem_req, busy}, if_rdata);
        end
        next_cycle(); settle();
        checks++;
        if ({err_timeout, if_rvalid} !== 2'b00) begin
            errors++; $display("FAIL to_pulse: got err/rv=%b want 00", {err_timeout, if_rvalid});
        end
    endtask

    task automatic test_ready_at_limit();
        next_cycle(); if_req = 1; if_addr = 32'h400; mem_ready = 0; mem_rdata = 32'h0; settle();
        for (int i = 1; i <= 16; i++) begin
            next_cycle(); if_req = 0; mem_ready = (i == 16); mem_rdata = (i == 16) ? 32'hBEEF : 32'h0;
        end
        settle();
        checks++;
        if ({mem_req, err_timeout} !== 2'b10) begin
            errors++; $display("FAIL lim_still_busy: got req/err=%b want 10", {mem_req, err_timeout});
        end
        next_cycle(); mem_ready = 0; mem_rdata = 32'h0; settle();
        checks++;
        if ({if_rvalid, err_timeout, busy} !== 3'b100 || if_rdata !== 32'hBEEF) begin
            errors++; $display("FAIL lim_complete: got rv/err/busy=%b rdata=%h want 100 beef",
                {if_rvalid, err_timeout, busy}, if_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [1:0] exp_gnt;
        next_cycle(); if_req = 1; if_addr = 32'h500; ma_req = 1; ma_we = 0; ma_addr = 32'h600;
        mem_ready = 1; mem_rdata = 32'hCAFE0000;
        for (int g = 0; g < 10; g++) begin
            exp_gnt = (g % 5 == 4) ? 2'b10 : 2'b01;
            settle();
            checks++;
            if ({if_gnt, ma_gnt} !== exp_gnt) begin
                errors++; $display("FAIL starve_gnt%0d: got if/ma=%b want %b", g, {if_gnt, ma_gnt}, exp_gnt);
            end
            next_cycle(); settle();
            checks++;
            if ({busy, if_gnt, ma_gnt} !== 3'b100) begin
                errors++; $display("FAIL starve_access%0d: got busy/ignt/mgnt=%b want 100",
                    g, {busy, if_gnt, ma_gnt});
            end
            next_cycle();
        end
        if_req = 0; ma_req = 0; settle();
        checks++;
        if ({if_rvalid, ma_rvalid} !== 2'b10) begin
            errors++; $display("FAIL starve_last_rv: got irv/mrv=%b want 10", {if_rvalid, ma_rvalid});
        end
    endtask

    task automatic test_reset_mid_access();
        next_cycle(); if_req = 1; ma_req = 1; ma_we = 0; mem_ready = 1; mem_rdata = 32'h77;
        for (int g = 0; g < 3; g++) begin
            next_cycle(); next_cycle();
        end
        settle();
        checks++;
        if (ma_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_pre_gnt: got %b want 1", ma_gnt);
        end
        next_cycle(); mem_ready = 0;
        next_cycle(); reset = 1; settle();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_pre_busy: got %b want 1", mem_req);
        end
        next_cycle(); reset = 0; settle();
        checks++;
        if ({mem_req, busy, if_rvalid, ma_rvalid, err_timeout} !== 5'b00000 || if_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_outputs: got req/busy/irv/mrv/err=%b if_rdata=%h want 00000 0",
                {mem_req, busy, if_rvalid, ma_rvalid, err_timeout}, if_rdata);
        end
        // A stale starve count of 4 would hand this grant to IF
        checks++;
        if ({if_gnt, ma_gnt} !== 2'b01) begin
            errors++; $display("FAIL rst_starve_cleared: got if/ma=%b want 01", {if_gnt, ma_gnt});
        end
        if_req = 0; ma_req = 0; settle();
        next_cycle(); next_cycle(); settle();
        checks++;
        if ({busy, if_rvalid, ma_rvalid} !== 3'b000) begin
            errors++; $display("FAIL rst_quiet: got busy/irv/mrv=%b want 000", {busy, if_rvalid, ma_rvalid});
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_wait_states();
        test_timeout();
        test_ready_at_limit();
        test_starvation();
        test_reset_mid_access();
        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the memory-access requester of the RV32I core.
- Sits between the fetch unit, the load/store unit and the external memory port.
- Serialises accesses, tolerates variable memory wait states and guarantees fetch forward progress under heavy load/store traffic.
- Aborts accesses that exceed a wait-state timeout.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
STARVE_LIMIT, 4, consecutive MA grants with if_req pending before IF is forced to win (must be >= 1)
MAX_WAIT, 15, cycles of mem_ready=0 in ACCESS before abort (must be >= 1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, fetch response valid
if_rdata  out  DATA_WIDTH  fetch read data, held until next if_rvalid
ma_req  in  1  load/store request; held with fields stable until ma_gnt
ma_we  in  1  1 = store, 0 = load
ma_addr  in  ADDR_WIDTH  load/store address
ma_wdata  in  DATA_WIDTH  store data
ma_gnt  out  1  load/store request accepted this cycle
ma_rvalid  out  1  one-cycle pulse, load data valid or store complete
ma_rdata  out  DATA_WIDTH  load data, held until next ma_rvalid for a load
mem_req  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ready  in  1  memory completes current access this cycle
mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ready=1
busy  out  1  1 while in ACCESS
err_timeout  out  1  one-cycle pulse on access abort

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE. Starve counter and wait counter go to 0.
  - All outputs go to 0, including rdata registers.
  - Reset during ACCESS drops mem_req after that edge and produces no rvalid.
- State machine: two states, IDLE and ACCESS.
- IDLE behaviour:
  - Arbitration is combinational. Exactly one of if_gnt/ma_gnt is asserted in the same cycle when any request is present.
  - On the following edge: state goes to ACCESS. Owner, address, we and wdata are latched. Wait counter is cleared.
  - Requesters may change or drop req the cycle after their gnt.
  - mem_ready is ignored in IDLE.
- Priority:
  - ma_req wins over if_req, except when the starve counter equals STARVE_LIMIT; then if_req wins.
  - An MA grant while if_req=1 increments the starve counter, saturating at STARVE_LIMIT.
  - An IF grant, or an MA grant while if_req=0, clears the counter.
- ACCESS behaviour:
  - mem_req=1. mem_addr, mem_we and mem_wdata are driven from the latched values and held stable until completion.
  - For IF accesses, mem_we=0 and mem_wdata=0. For MA loads, mem_wdata=0.
- Completion:
  - A cycle in ACCESS with mem_ready=1 completes the access. The next edge returns to IDLE.
  - On that edge, the owner's rvalid is set for exactly one cycle.
  - For reads, mem_rdata is captured into the owner's rdata.
  - For stores, ma_rvalid pulses and ma_rdata is unchanged.
- Latency:
  - Request seen in IDLE at cycle t gives gnt at t, mem_req high from t+1, mem_ready at t+k (k >= 1), rvalid at t+k+1.
  - The rvalid cycle is an IDLE cycle and can grant the next request.
  - Minimum spacing between accesses is 2 cycles.
- Timeout:
  - In ACCESS, each cycle with mem_ready=0 increments the wait counter.
  - When the counter equals MAX_WAIT with mem_ready still 0, the next edge returns to IDLE and drops mem_req.
  - On that same edge: err_timeout pulses for one cycle, the owner's rvalid pulses, and for reads the owner's rdata is set to 0.
  - mem_ready=1 in the same cycle as the count reaching MAX_WAIT counts as a normal completion, with no error.
- busy = (state == ACCESS).
- gnt is never asserted in ACCESS. if_rvalid and ma_rvalid are never asserted in the same cycle.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100 at cycle 0; mem_ready=1 at cycle 1 with mem_rdata=0x00500093. Required: if_gnt at 0, mem_req/mem_addr=0x100/mem_we=0 at 1, if_rvalid with if_rdata=0x00500093 at 2, busy=0 at 2.
- Simultaneous requests: if_req and ma_req (store, addr 0x2000, wdata 0xDEADBEEF) at cycle 0, mem_ready always 1. Required: ma_gnt at 0, mem_we=1/mem_wdata=0xDEADBEEF at 1, ma_rvalid at 2, if_gnt at 2.
- Starvation: ma_req and if_req held high continuously, mem_ready=1. Required: grants MA, MA, MA, MA, then IF on the 5th grant, then the pattern repeats.
- Wait states: load at 0x40, mem_ready low for 3 cycles then high with rdata=0x1234. Required: mem fields stable for 4 cycles, ma_rvalid with ma_rdata=0x1234 one cycle after mem_ready, err_timeout=0.
- Timeout: fetch with mem_ready held 0. Required: after MAX_WAIT=15 wait cycles, err_timeout and if_rvalid pulse together, if_rdata=0, mem_req=0, state IDLE.
- Reset mid-access: reset=1 on the second ACCESS cycle. Required: the next cycle has mem_req=0, busy=0, no rvalid, and the starve counter cleared.
